hpdcache_sram_ctrl: RTL and testbench
=====================================

Name: hpdcache_sram_ctrl

Overview:
- Initiator-side controller for the single-port 1RW cache SRAM (cs/we/addr/wdata/rdata, 1-cycle read latency, no write mask).
- Accepts valid/ready requests from the cache datapath and drives SRAM cycles.
- Emulates byte-enable writes by read-modify-write.
- Returns read data through a backpressurable response channel, so no SRAM read data is ever lost.

Parameters:
- ADDR_SIZE, 8, SRAM address width.
- DATA_SIZE, 256, SRAM word width in bits; must be a multiple of 8.
- DEPTH, 2**ADDR_SIZE, number of SRAM words.
- BE_SIZE, DATA_SIZE/8, byte-enable width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_SIZE  word address
- req_wdata  in  DATA_SIZE  write data
- req_be  in  BE_SIZE  byte enables (writes only)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_SIZE  read data
- busy  out  1  RMW or init in progress
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_SIZE  SRAM address
- sram_wdata  out  DATA_SIZE  SRAM write data
- sram_rdata  in  DATA_SIZE  SRAM read data, valid the cycle after a read cs

Behaviour:
- Reset: synchronous, active-low on clk. While rst_n=0 and on the first cycle after release:
  - req_ready=0, rsp_valid=0, sram_cs=0, sram_we=0, busy=0.
  - Response FIFO emptied; any in-flight read or RMW is discarded.
- FSM states: IDLE, RMW_WR, plus INIT when the optional feature is compiled in.
- IDLE:
  - req_ready = (fifo_count + rd_inflight < 2). The condition does not depend on req_valid or req_we.
  - On a handshake the SRAM access is issued combinationally in the same cycle (sram_cs=1, sram_addr=req_addr).
- Read: sram_we=0. rd_inflight is set for one cycle. On the next cycle sram_rdata is pushed into the response FIFO.
- Full write (be all ones): sram_we=1, sram_wdata=req_wdata. Single cycle; no response is generated.
- Null write (be all zeros): accepted; no SRAM access; no response.
- Partial write, cycle 0:
  - Issue a read of req_addr.
  - Latch addr, wdata and be.
  - Go to RMW_WR.
- RMW_WR, cycle 1:
  - sram_cs=1, sram_we=1.
  - sram_wdata per byte b = be[b] ? wdata_q byte b : sram_rdata byte b.
  - busy=1, req_ready=0. Return to IDLE.
  - The RMW read is never pushed to the FIFO.
- Accepted throughput: one request per cycle, except a partial write, which costs 2 cycles.
- Ordering: strictly in order. A read issued immediately after an RMW sees the merged data.
- Response FIFO:
  - Depth 2, first-word fall-through.
  - rsp_valid = fifo not empty; rsp_rdata = head.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are legal, including when full.
  - The credit rule above guarantees a push never hits a full FIFO; an assertion checks this.
- Read latency: request handshake at cycle N gives rsp_valid at cycle N+1.
- Simultaneous events: with rsp_ready=0, two back-to-back reads are accepted and req_ready then drops to 0 until the first pop.

Optional Feature:
- Macro: HPDCACHE_SRAM_CTRL_INIT_EN.
- Defined:
  - After reset the FSM enters INIT and writes zero to addresses 0..DEPTH-1, one per cycle (sram_cs=1, sram_we=1).
  - During INIT: busy=1, req_ready=0. Then the FSM enters IDLE.
  - Total DEPTH cycles. Reset mid-INIT restarts the sweep at address 0.
- Undefined: no INIT state; the FSM enters IDLE on the first cycle after reset.

Decomposition:
- Package hpdcache_sram_ctrl_pkg: FSM state enum and constant RSP_FIFO_DEPTH=2.
- Sub-module hpdcache_sram_ctrl_rsp_fifo: 2-entry FWD FIFO with count output, parameterised on DATA_SIZE.
- Byte-merge logic stays in the top module.

Test Plan:
- Full write 0xA5.. to addr 3, then read addr 3 -> rsp_rdata=0xA5.. exactly 1 cycle after the read handshake; no response for the write.
- Word at addr 7 = all 0x11; partial write be=0x1, wdata all 0xFF -> after 2 cycles a read returns byte0=0xFF and all other bytes 0x11; req_ready=0 and busy=1 during RMW_WR.
- Hold rsp_ready=0; issue reads to addr 1, 2, 3 -> first two accepted, req_ready=0 until a pop; data then returned in order 1, 2, 3.
- be=0 write to addr 5 holding 0x22.. -> no sram_cs asserted; a subsequent read returns 0x22...
- Drop rst_n during RMW_WR and with 2 responses queued -> next cycle sram_cs=0, rsp_valid=0; FIFO empty after release.
- With HPDCACHE_SRAM_CTRL_INIT_EN and DEPTH=256 -> busy=1 for 256 cycles, then reads of addr 0 and addr 255 return 0.

Source files
------------

// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and constants for the HPDcache SRAM controller.
// HPDCACHE_SRAM_CTRL_INIT_EN adds the INIT state used by the post-reset zeroing sweep.
package hpdcache_sram_ctrl_pkg;

    localparam int RSP_FIFO_DEPTH = 2;
    localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int RSP_PTR_W      = $clog2(RSP_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RMW_WR
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        ,
        INIT
`endif
    } state_e;

endpackage

// File: rtl/hpdcache_sram_ctrl_rsp_fifo.sv
// Two-entry first-word fall-through response FIFO; an incoming word bypasses straight to
// the head when the FIFO is empty, so read data is visible the cycle it leaves the SRAM.
module hpdcache_sram_ctrl_rsp_fifo
    import hpdcache_sram_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] head,
    output logic [RSP_CNT_W-1:0] count
);

    logic [DATA_SIZE-1:0] mem [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0] wr_ptr_q;
    logic [RSP_PTR_W-1:0] rd_ptr_q;
    logic [RSP_CNT_W-1:0] count_q;
    logic                 empty;
    logic                 do_pop;
    logic                 store;
    logic                 drain;

    assign empty  = (count_q == '0);
    assign valid  = push || !empty;
    assign head   = empty ? push_data : mem[rd_ptr_q];
    assign do_pop = pop && valid;
    // A word pushed and popped in the same cycle while empty is never stored.
    assign store  = push && !(do_pop && empty);
    assign drain  = do_pop && !empty;
    assign count  = count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + RSP_PTR_W'(1);
            if (drain) rd_ptr_q <= rd_ptr_q + RSP_PTR_W'(1);
            count_q <= count_q + RSP_CNT_W'(push) - RSP_CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= push_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && count_q == RSP_CNT_W'(RSP_FIFO_DEPTH)));

endmodule

// File: rtl/hpdcache_sram_ctrl.sv
// HPDcache SRAM controller: valid/ready requests in, 1RW SRAM cycles out, byte-enable writes by
// read-modify-write. Defining HPDCACHE_SRAM_CTRL_INIT_EN zeroes the whole SRAM after reset.
module hpdcache_sram_ctrl
    import hpdcache_sram_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 256,
    parameter int DEPTH     = 2**ADDR_SIZE,
    parameter int BE_SIZE   = DATA_SIZE/8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    input  logic [BE_SIZE-1:0]   req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata
);

    state_e               state_q;
    logic                 run_q;
    logic                 rd_inflight_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [BE_SIZE-1:0]   be_q;
    logic [DATA_SIZE-1:0] merged;
    logic [RSP_CNT_W-1:0] fifo_count;
    logic                 fifo_valid;
    logic                 credit_ok;
    logic                 req_hs;
    logic                 null_wr;
    logic                 full_wr;
    logic                 part_wr;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(DEPTH - 1);
    logic [ADDR_SIZE-1:0] init_addr_q;
`endif

    // Credits cover both queued words and the read whose data arrives next cycle.
    assign credit_ok = (int'(fifo_count) + int'(rd_inflight_q)) < RSP_FIFO_DEPTH;
    assign req_ready = rst_n && run_q && (state_q == IDLE) && credit_ok;
    assign req_hs    = req_valid && req_ready;
    assign null_wr   = req_we && (req_be == '0);
    assign full_wr   = req_we && (&req_be);
    assign part_wr   = req_we && !null_wr && !full_wr;
    assign busy      = rst_n && (state_q != IDLE);
    assign rsp_valid = rst_n && fifo_valid;

    always_comb begin
        merged = sram_rdata;
        for (int b = 0; b < BE_SIZE; b++) begin
            if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        // The SRAM is held quiet while rst_n is low, so a reset aborts a pending RMW write.
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req_hs && !null_wr) begin
                        sram_cs = 1'b1;
                        sram_we = full_wr;
                    end
                end
                RMW_WR: begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = addr_q;
                    sram_wdata = merged;
                end
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
                INIT: begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = init_addr_q;
                    sram_wdata = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
            init_addr_q   <= '0;
`endif
        end else begin
            run_q         <= 1'b1;
            rd_inflight_q <= req_hs && !req_we;
            case (state_q)
                IDLE: begin
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
                    if (!run_q) begin
                        state_q     <= INIT;
                        init_addr_q <= '0;
                    end else
`endif
                    if (req_hs && part_wr) state_q <= RMW_WR;
                end
                RMW_WR: state_q <= IDLE;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
                INIT: begin
                    init_addr_q <= init_addr_q + ADDR_SIZE'(1);
                    if (init_addr_q == INIT_LAST) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs && part_wr) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    hpdcache_sram_ctrl_rsp_fifo #(
        .DATA_SIZE (DATA_SIZE)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight_q),
        .push_data (sram_rdata),
        .pop       (rsp_ready),
        .valid     (fifo_valid),
        .head      (rsp_rdata),
        .count     (fifo_count)
    );

    addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        !sram_cs || (int'(sram_addr) < DEPTH));

endmodule

// File: tb/tb_hpdcache_sram_ctrl.sv
// Directed bench for hpdcache_sram_ctrl: a behavioural 1RW SRAM, a read-data scoreboard
// fed at request handshake and drained by an independent response monitor.
module tb_hpdcache_sram_ctrl;

    localparam int AW = 8;
    localparam int DW = 256;
    localparam int BW = DW/8;

    localparam logic [DW-1:0] D_A5  = {32{8'hA5}};
    localparam logic [DW-1:0] D_11  = {32{8'h11}};
    localparam logic [DW-1:0] D_FF  = {32{8'hFF}};
    localparam logic [DW-1:0] D_01  = {32{8'h01}};
    localparam logic [DW-1:0] D_02  = {32{8'h02}};
    localparam logic [DW-1:0] D_22  = {32{8'h22}};
    localparam logic [DW-1:0] D_AB  = {32{8'hAB}};
    localparam logic [DW-1:0] D_RMW = {{31{8'h11}}, 8'hFF};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] sram_mem [256] = '{default: {32{8'hEE}}};

    always #5 clk = ~clk;

    hpdcache_sram_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expected read.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got %h, expected no response", rsp_rdata);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Presents one request, waits (bounded) for acceptance, and records the expected read data.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [BW-1:0] be, input logic [DW-1:0] exp_rd,
                         output int waited, output logic hs_cs, output logic hs_we);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        hs_cs = sram_cs;
        hs_we = sram_we;
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: addr %0d, req_ready %b, expected 1", addr, req_ready);
        end else if (!we) begin
            exp_q.push_back(exp_rd);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_bit("ready_after_reset", req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   w;
        logic hc;
        logic hw;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        int   n;
`endif
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_sram_cs", sram_cs, 1'b0);
        check_bit("rst_sram_we", sram_we, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("rel_req_ready", req_ready, 1'b0);
        check_bit("rel_busy", busy, 1'b0);
        check_bit("rel_sram_cs", sram_cs, 1'b0);

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        n = 0;
        @(negedge clk);
        check_bit("init_sram_we", sram_we, 1'b1);
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_int("init_busy_cycles", n, 256);
        @(posedge clk);
        #1;
        issue(1'b0, 8'd0, '0, '0, '0, w, hc, hw);
        issue(1'b0, 8'd255, '0, '0, '0, w, hc, hw);
`else
        @(posedge clk);
        #1;
`endif

        // Full write then read-back, response one cycle after the read handshake.
        issue(1'b1, 8'd3, D_A5, '1, '0, w, hc, hw);
        check_bit("full_wr_cs", hc, 1'b1);
        check_bit("full_wr_we", hw, 1'b1);
        issue(1'b0, 8'd3, '0, '0, D_A5, w, hc, hw);
        check_bit("rd_we", hw, 1'b0);
        @(negedge clk);
        check_bit("rd_latency_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;

        // Partial write by read-modify-write, then an immediate read of the merged word.
        issue(1'b1, 8'd7, D_11, '1, '0, w, hc, hw);
        issue(1'b1, 8'd7, D_FF, 32'h1, '0, w, hc, hw);
        check_bit("rmw_rd_cs", hc, 1'b1);
        check_bit("rmw_rd_we", hw, 1'b0);
        @(negedge clk);
        check_bit("rmw_req_ready", req_ready, 1'b0);
        check_bit("rmw_busy", busy, 1'b1);
        check_bit("rmw_wr_we", sram_we, 1'b1);
        check_int("rmw_wr_addr", int'(sram_addr), 7);
        check("rmw_wr_data", sram_wdata, D_RMW);
        @(posedge clk);
        #1;
        issue(1'b0, 8'd7, '0, '0, D_RMW, w, hc, hw);
        check_int("rd_after_rmw_wait", w, 0);

        // Backpressure: two reads fit, the third waits for a pop, data stays in order.
        issue(1'b1, 8'd1, D_01, '1, '0, w, hc, hw);
        issue(1'b1, 8'd2, D_02, '1, '0, w, hc, hw);
        rsp_ready = 1'b0;
        issue(1'b0, 8'd1, '0, '0, D_01, w, hc, hw);
        check_int("bp_rd1_wait", w, 0);
        issue(1'b0, 8'd2, '0, '0, D_02, w, hc, hw);
        check_int("bp_rd2_wait", w, 0);
        repeat (3) begin
            @(negedge clk);
            check_bit("bp_req_ready_low", req_ready, 1'b0);
        end
        check_bit("bp_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(1'b0, 8'd3, '0, '0, D_A5, w, hc, hw);
        check_int("bp_rd3_wait", w, 1);

        // Null write: accepted without an SRAM cycle, old data survives.
        issue(1'b1, 8'd5, D_22, '1, '0, w, hc, hw);
        issue(1'b1, 8'd5, D_FF, '0, '0, w, hc, hw);
        check_bit("null_wr_cs", hc, 1'b0);
        issue(1'b0, 8'd5, '0, '0, D_22, w, hc, hw);
        repeat (2) @(posedge clk);
        #1;

        // Reset during RMW_WR: the merge write must not reach the SRAM.
        issue(1'b1, 8'd7, D_AB, 32'h2, '0, w, hc, hw);
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("rst_rmw_cs_now", sram_cs, 1'b0);
        @(negedge clk);
        check_bit("rst_rmw_cs_next", sram_cs, 1'b0);
        check_bit("rst_rmw_busy_next", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready();
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
        issue(1'b0, 8'd7, '0, '0, '0, w, hc, hw);
`else
        issue(1'b0, 8'd7, '0, '0, D_RMW, w, hc, hw);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset with two responses queued: both are dropped.
        rsp_ready = 1'b0;
        issue(1'b0, 8'd1, '0, '0, '0, w, hc, hw);
        issue(1'b0, 8'd2, '0, '0, '0, w, hc, hw);
        @(negedge clk);
        check_bit("two_queued_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_bit("rst_q_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_q_sram_cs", sram_cs, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wait_ready();
        @(negedge clk);
        check_bit("fifo_empty_after_rst", rsp_valid, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
